serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: the inverse operation of the team's 4-bit adder.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 164 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b mod 2^WIDTH), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic logic fs_diff(input logic x, input logic y, input logic bw);
        return x ^ y ^ bw;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bw);
        return (~x & y) | (~(x ^ y) & bw);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bw_q, bw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept_s;
    logic             last_s;
    logic             d_s;
    logic             bw_next_s;

    // Full-subtractor cell on the current LSBs and the borrow flop.
    always_comb begin
        d_s       = fs_diff(a_q[0], b_q[0], bw_q);
        bw_next_s = fs_borrow(a_q[0], b_q[0], bw_q);
        accept_s  = (state_q == IDLE) && in_ready_q && bus.in_valid;
        last_s    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        bw_d    = bw_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    res_d   = {WIDTH{1'b0}};
                    bw_d    = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                res_d = {d_s, res_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                bw_d  = bw_next_s;
                // Counter parks at zero on the last bit so it never wraps.
                if (last_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and handshake flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            bw_q        <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            bw_q        <= bw_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // Signed overflow: operand signs differ and the result sign disagrees with a.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (accept_s) begin
            a_msb_d = bus.a[WIDTH-1];
            b_msb_d = bus.b[WIDTH-1];
            ovf_d   = 1'b0;
        end else if (last_s) begin
            ovf_d = (a_msb_q != b_msb_q) && (d_s != a_msb_q);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow capture flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = res_q;
    assign bus.borrow    = bw_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive self-checking bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;
    localparam int WIDTH = 4;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Waits for out_valid after the accept edge; returns edges counted.
    task automatic wait_valid(output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!bus.out_valid && edges < 20);
        check_eq("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    // Accepts one operand pair, checks latency and result; leaves the DUT in DONE.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_diff, input logic exp_borrow, input logic exp_ovf);
        int edges;
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_eq({tag, "_in_ready_drop"}, 32'(bus.in_ready), 32'd0);
        wait_valid(edges);
        check_eq({tag, "_latency"}, 32'(edges), 32'(WIDTH));
        check_eq({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
        check_eq({tag, "_borrow"}, 32'(bus.borrow), 32'(exp_borrow));
        check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf && OVF_EN));
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int edges;
        int last_acc;
        int guard;
        logic [3:0] ed;
        logic       eb;
        logic       eo;

        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 4'd0;
        bus.b         = 4'd0;
        bus.out_ready = 1'b0;

        // Reset values
        #3;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_diff", 32'(bus.diff), 32'd0);
        check_eq("rst_borrow", 32'(bus.borrow), 32'd0);
        check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        check_eq("rel_in_ready_still_low", 32'(bus.in_ready), 32'd0);
        tick();
        check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed operations
        run_op("op_7_3", 4'd7, 4'd3, 4'd4, 1'b0, 1'b0);
        release_result("op_7_3");
        run_op("op_3_7", 4'd3, 4'd7, 4'd12, 1'b1, 1'b0);
        release_result("op_3_7");
        run_op("op_8_1", 4'd8, 4'd1, 4'd7, 1'b0, 1'b1);
        release_result("op_8_1");
        run_op("op_9_9", 4'd9, 4'd9, 4'd0, 1'b0, 1'b0);
        release_result("op_9_9");

        // Backpressure in DONE with in_valid asserted
        run_op("bp", 4'd5, 4'd9, 4'd12, 1'b1, 1'b1);
        bus.a        = 4'd1;
        bus.b        = 4'd2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("bp_diff", 32'(bus.diff), 32'd12);
            check_eq("bp_borrow", 32'(bus.borrow), 32'd1);
            check_eq("bp_ovf", 32'(bus.ovf), 32'(OVF_EN));
        end
        bus.in_valid = 1'b0;
        release_result("bp");
        run_op("after_bp", 4'd2, 4'd5, 4'd13, 1'b1, 1'b0);
        release_result("after_bp");

        // Reset during SHIFT at cnt=2
        bus.a        = 4'd6;
        bus.b        = 4'd1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_diff", 32'(bus.diff), 32'd0);
        check_eq("mid_rst_borrow", 32'(bus.borrow), 32'd0);
        check_eq("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        tick();
        tick();
        check_eq("mid_rst_no_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("mid_rst_in_ready_back", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("mid_rst_idle_no_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op("op_0_15", 4'd0, 4'd15, 4'd1, 1'b1, 1'b0);
        release_result("op_0_15");

        // Exhaustive back-to-back with out_ready tied high
        bus.out_ready = 1'b1;
        last_acc      = -1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                bus.a        = 4'(i);
                bus.b        = 4'(j);
                bus.in_valid = 1'b1;
                guard        = 0;
                while (!bus.in_ready && guard < 20) begin
                    tick();
                    guard++;
                end
                check_eq("ex_ready_timeout", 32'(bus.in_ready), 32'd1);
                tick();
                if (last_acc >= 0) begin
                    check_eq("ex_spacing", 32'(cyc - last_acc), 32'(WIDTH + 2));
                end else begin
                    last_acc = cyc;
                end
                last_acc = cyc;
                wait_valid(edges);
                ed = 4'(i - j);
                eb = (i < j);
                eo = (ed[3] != 4'(i) >> 3) && ((4'(i) >> 3) != (4'(j) >> 3));
                check_eq("ex_latency", 32'(edges), 32'(WIDTH));
                check_eq("ex_diff", 32'(bus.diff), 32'(ed));
                check_eq("ex_borrow", 32'(bus.borrow), 32'(eb));
                check_eq("ex_ovf", 32'(bus.ovf), 32'(eo && OVF_EN));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        check_eq("ex_end_idle", 32'(bus.in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
